pc_unit: RTL
============

// Module: pc_unit
// PURPOSE
//  Parametrised program-counter unit for the multicycle CPU; successor to the single 9-bit enable-gated PC.
//  Holds the PC and selects the next PC from: sequential, branch target, jump target, return stack, exception vector.
//  Adds an asynchronous active-low reset to a fixed vector, conditional (branch) writes, and a RAS_DEPTH return-address stack.
//  Sits between the control FSM (write strobes, source select) and the ALU/IR (targets, zero flag).
// PARAMETERS
//  PC_W       9      PC width in bits; all PC arithmetic is modulo 2**PC_W
//  INC        1      sequential increment (word-addressed memory)
//  RESET_VEC  0      PC value after reset
//  EXC_VEC    9'h1F0 PC loaded on exception
//  RAS_DEPTH  4      return-address stack entries (power of 2, >=2)
// PORTS
//  clk            in   1         clock; all state changes on rising edge
//  rst_n          in   1         asynchronous reset, active low
//  pc_write       in   1         unconditional PC update strobe
//  pc_write_cond  in   1         PC update only if zero=1 (branch)
//  zero           in   1         ALU zero flag
//  pc_src         in   2         00 seq, 01 branch tgt, 10 jump tgt, 11 return (RAS pop)
//  target         in   PC_W      branch/jump target computed outside
//  call           in   1         with update & pc_src=10: push pc_out+INC
//  exc            in   1         exception request; overrides all sources
//  pc_out         out  PC_W      current PC (registered)
//  pc_seq         out  PC_W      pc_out+INC, combinational
//  ras_empty      out  1         stack holds 0 entries
//  ras_full       out  1         stack holds RAS_DEPTH entries
//  ras_err        out  1         sticky: overflow or underflow occurred
// BEHAVIOUR
//  Reset (rst_n=0, async): pc_out=RESET_VEC, stack count=0, ras_empty=1, ras_full=0, ras_err=0; RAS contents don't-care.
//  update = exc | pc_write | (pc_write_cond & zero); no update -> all state holds.
//  Next PC on update, priority: exc -> EXC_VEC; else pc_src 00 -> pc_seq, 01 -> target, 10 -> target, 11 -> RAS top.
//  Latency: new pc_out visible the cycle after the qualifying edge; pc_seq follows pc_out combinationally.
//  Wrap: pc_seq = (pc_out+INC) mod 2**PC_W; max PC + INC wraps to low address, no flag.
//  Push: update & ~exc & pc_src=10 & call -> push pc_seq. If full, oldest entry overwritten (circular), count stays
//   RAS_DEPTH, ras_err set.
//  Pop: update & ~exc & pc_src=11 -> next PC = top, count-1. If empty: next PC = target, count stays 0, ras_err set.
//  call with pc_src!=10 ignored for RAS; pc_src=11 with call: pop only (no push).
//  exc suppresses all RAS activity that cycle; RAS contents/count preserved.
//  pc_write_cond with zero=0 and no pc_write/exc: no update, no RAS change.
//  ras_err cleared only by reset. ras_empty/ras_full registered-state derived, valid same cycle as count.
//  Reset asserted mid-operation overrides any in-flight update; release is synchronised externally.
// STRUCTURE
//  Shared package cpu_pkg: PC_W, RESET_VEC, EXC_VEC, pc_src encodings (PC_SEQ, PC_BR, PC_JMP, PC_RET).
//  One sub-module: ras_stack (circular buffer + count, push/pop/overwrite-on-full, err output).
//  pc_unit = next-PC mux + PC register + ras_stack instance.
// TESTING
//  Reset: rst_n low mid-cycle with pc_out=9'h055 -> pc_out=0 immediately, ras_empty=1, ras_err=0.
//  Seq/wrap: pc_out=9'h1FF, pc_write=1, pc_src=00 -> pc_out=9'h000 next cycle; pc_write=0 -> PC holds.
//  Branch: pc_write_cond=1, target=9'h040, zero=0 -> PC unchanged; zero=1 -> pc_out=9'h040.
//  Call/return: at PC 9'h010 jump+call to 9'h080; then pc_src=11 -> pc_out=9'h011, ras_empty=1.
//  Overflow/underflow: 5 calls (depth 4) -> ras_full=1, ras_err=1, 4 pops return last 4 addresses; 5th pop -> PC=target.
//  Exception: exc=1 with pc_src=11, call=1 -> pc_out=EXC_VEC, RAS count unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU constants and program-counter source encodings.
// Used by the PC unit and the control FSM.
package cpu_pkg;

  localparam int PC_W = 9;
  localparam int INC = 1;
  localparam int RAS_DEPTH = 4;
  localparam logic [PC_W-1:0] RESET_VEC = '0;
  localparam logic [PC_W-1:0] EXC_VEC = 9'h1F0;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10,
    PC_RET = 2'b11
  } pc_src_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack with occupancy count.
// A push when full overwrites the oldest entry and flags an error.
module ras_stack #(
  parameter int W = 9,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full,
  output logic         err
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] sp;
  logic [AW:0] cnt;

  assign empty = (cnt == '0);
  assign full = (cnt == (AW+1)'(DEPTH));
  assign top = mem[sp - AW'(1)];

  always_ff @(posedge clk) begin
    if (push)
      mem[sp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
      cnt <= '0;
      err <= 1'b0;
    end else if (push) begin
      sp <= sp + AW'(1);
      if (full)
        err <= 1'b1;
      else
        cnt <= cnt + (AW+1)'(1);
    end else if (pop) begin
      if (empty) begin
        err <= 1'b1;
      end else begin
        sp <= sp - AW'(1);
        cnt <= cnt - (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with next-PC select, exception vector
// and return-address stack.
module pc_unit #(
  parameter int PC_W = cpu_pkg::PC_W,
  parameter int INC = cpu_pkg::INC,
  parameter logic [PC_W-1:0] RESET_VEC = PC_W'(cpu_pkg::RESET_VEC),
  parameter logic [PC_W-1:0] EXC_VEC = PC_W'(cpu_pkg::EXC_VEC),
  parameter int RAS_DEPTH = cpu_pkg::RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pc_write,
  input  logic            pc_write_cond,
  input  logic            zero,
  input  logic [1:0]      pc_src,
  input  logic [PC_W-1:0] target,
  input  logic            call,
  input  logic            exc,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] pc_seq,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            ras_err
);

  import cpu_pkg::*;

  logic update;
  logic push;
  logic pop;
  logic [PC_W-1:0] ras_top;
  logic [PC_W-1:0] pc_next;

  assign update = exc | pc_write | (pc_write_cond & zero);
  assign push = update & ~exc & (pc_src == PC_JMP) & call;
  assign pop = update & ~exc & (pc_src == PC_RET);
  assign pc_seq = pc_out + PC_W'(INC);

  always_comb begin
    pc_next = pc_seq;
    if (exc) begin
      pc_next = EXC_VEC;
    end else begin
      unique case (pc_src)
        PC_SEQ: pc_next = pc_seq;
        PC_BR:  pc_next = target;
        PC_JMP: pc_next = target;
        PC_RET: pc_next = ras_empty ? target : ras_top;
        default: pc_next = pc_seq;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc_out <= RESET_VEC;
    else if (update)
      pc_out <= pc_next;
  end

  ras_stack #(
    .W(PC_W),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(pc_seq),
    .top(ras_top),
    .empty(ras_empty),
    .full(ras_full),
    .err(ras_err)
  );

endmodule
